// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on the memory req/ready handshake and traps unknown opcodes/functs.
module multicycle_ctrl #(
    parameter int          OP_W         = 6,
    parameter int          FUNCT_W      = 6,
    parameter int          ALU_OP_W     = 4,
    parameter logic [1:0]  TRAP_VEC_SEL = 2'b11
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                run,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                ext_op,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'('h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'('h02);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'('h03);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'('h04);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'('h05);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'('h08);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'('h0D);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'('h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'('h2B);

    localparam logic [FUNCT_W-1:0] F_ADD  = FUNCT_W'('h20);
    localparam logic [FUNCT_W-1:0] F_ADDU = FUNCT_W'('h21);
    localparam logic [FUNCT_W-1:0] F_SUB  = FUNCT_W'('h22);
    localparam logic [FUNCT_W-1:0] F_SUBU = FUNCT_W'('h23);
    localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'('h24);
    localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'('h25);
    localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'('h2A);
    localparam logic [FUNCT_W-1:0] F_SLTU = FUNCT_W'('h2B);

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_NOP  = '1;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [ALU_OP_W-1:0] r_alu;
    logic                r_ok;

    // R-type funct decode; r_ok low sends EXEC_R to TRAP
    always_comb begin
        r_alu = ALU_NOP;
        r_ok  = 1'b1;
        case (funct)
            F_ADD, F_ADDU: r_alu = ALU_ADD;
            F_SUB, F_SUBU: r_alu = ALU_SUB;
            F_AND:         r_alu = ALU_AND;
            F_OR:          r_alu = ALU_OR;
            F_SLT:         r_alu = ALU_SLT;
            F_SLTU:        r_alu = ALU_SLTU;
            default:       r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        alu_op     = ALU_NOP;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                alu_op    = ALU_ADD;
                case (op)
                    OP_RTYPE:       state_d = S_EXEC_R;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_ADDI, OP_ORI: state_d = S_EXEC_I;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_alu;
                state_d   = r_ok ? S_WB_ALU : S_TRAP;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (op == OP_ORI) begin
                    alu_op = ALU_OR;
                end else begin
                    ext_op = 1'b1;
                    alu_op = ALU_ADD;
                end
                state_d = S_WB_ALU;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = (op == OP_RTYPE) ? 2'b01 : 2'b00;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                alu_op    = ALU_ADD;
                state_d   = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = (op == OP_BNE) ? ~zero : zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                // PC already holds PC+4, so it is the link value
                if (op == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                pc_write = 1'b1;
                pc_src   = TRAP_VEC_SEL;
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // flag rises as TRAP is entered so it is visible during the trap cycle
    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// trace from the instruction-level rules, then replayed against the DUT.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rstn, run, zero, mem_ready;
    logic [5:0] op, funct;
    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic       alu_src_a, ext_op, illegal;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0] alu_op, state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rstn(rstn), .run(run), .op(op), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
        .illegal(illegal), .state(state)
    );

    logic [21:0] obs;
    assign obs = {illegal, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op};

    typedef struct {
        logic [3:0]  st;
        logic [21:0] ctl;
        bit          rdy;
        bit          run;
    } step_t;

    step_t      q[$];
    int         n_chk = 0, n_fail = 0;
    bit         ill_m = 0;
    logic [5:0] cur_op, cur_funct;
    bit         cur_zero;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3,
                           SLT = 4'd4, SLTU = 4'd5, NOP = 4'hF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [21:0] mk(input bit ill, req, we, io, irw, pcw,
                                       input logic [1:0] pcs, input bit rw,
                                       input logic [1:0] rd, m2r, input bit asa,
                                       input logic [1:0] asb, input bit ext,
                                       input logic [3:0] aop);
        return {ill, req, we, io, irw, pcw, pcs, rw, rd, m2r, asa, asb, ext, aop};
    endfunction

    function automatic int funct_alu(input logic [5:0] f);
        case (f)
            6'h20, 6'h21: return ADD;
            6'h22, 6'h23: return SUB;
            6'h24: return AND_;
            6'h25: return OR_;
            6'h2A: return SLT;
            6'h2B: return SLTU;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal_op(input logic [5:0] o);
        case (o)
            6'h00, 6'h23, 6'h2B, 6'h08, 6'h0D, 6'h04, 6'h05, 6'h02, 6'h03: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic [3:0] st, input logic [21:0] ctl, input bit rdy);
        step_t s;
        s.st = st; s.ctl = ctl; s.rdy = rdy; s.run = 1'($urandom_range(0, 1));
        q.push_back(s);
    endtask

    task automatic push_trap();
        ill_m = 1'b1;
        push(4'd12, mk(1, 0,0,0,0,1, 2'b11, 0, 2'b00, 2'b00, 0, 2'b00, 0, NOP), 1'($urandom_range(0, 1)));
    endtask

    // Expected cycle trace of one instruction, fetch wait fw, memory wait mw
    task automatic add_instr(input logic [5:0] o, f, input bit z, input int fw, mw);
        int a;
        bit r;
        cur_op = o; cur_funct = f; cur_zero = z;
        r = 1'($urandom_range(0, 1));
        for (int i = 0; i < fw; i++)
            push(4'd1, mk(ill_m, 1,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 0, ADD), 1'b0);
        push(4'd1, mk(ill_m, 1,0,0,1,1, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 0, ADD), 1'b1);
        push(4'd2, mk(ill_m, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b11, 1, ADD), r);
        case (o)
            6'h00: begin
                a = funct_alu(f);
                push(4'd3, mk(ill_m, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 0,
                              (a < 0) ? NOP : a[3:0]), r);
                if (a < 0) push_trap();
                else push(4'd8, mk(ill_m, 0,0,0,0,0, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 0, NOP), r);
            end
            6'h23, 6'h2B: begin
                push(4'd5, mk(ill_m, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 1, ADD), r);
                for (int i = 0; i <= mw; i++)
                    push((o == 6'h23) ? 4'd6 : 4'd7,
                         mk(ill_m, 1, (o == 6'h2B), 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 0, NOP),
                         (i == mw));
                if (o == 6'h23)
                    push(4'd9, mk(ill_m, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b01, 0, 2'b00, 0, NOP), r);
            end
            6'h08, 6'h0D: begin
                push(4'd4, mk(ill_m, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10,
                              (o == 6'h08), (o == 6'h08) ? ADD : OR_), r);
                push(4'd8, mk(ill_m, 0,0,0,0,0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 0, NOP), r);
            end
            6'h04, 6'h05:
                push(4'd10, mk(ill_m, 0,0,0,0, (o == 6'h04) ? z : !z, 2'b01, 0, 2'b00, 2'b00,
                               1, 2'b00, 0, SUB), r);
            6'h02:
                push(4'd11, mk(ill_m, 0,0,0,0,1, 2'b10, 0, 2'b00, 2'b00, 0, 2'b00, 0, NOP), r);
            6'h03:
                push(4'd11, mk(ill_m, 0,0,0,0,1, 2'b10, 1, 2'b10, 2'b10, 0, 2'b00, 0, NOP), r);
            default: push_trap();
        endcase
    endtask

    task automatic run_steps(input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            @(negedge clk);
            run = s.run; mem_ready = s.rdy;
            op = cur_op; funct = cur_funct; zero = cur_zero;
            #1;
            chk("state", 32'(state), 32'(s.st));
            chk("ctl", 32'(obs), 32'(s.ctl));
        end
    endtask

    task automatic do_instr(input logic [5:0] o, f, input bit z, input int fw, mw);
        add_instr(o, f, z, fw, mw);
        run_steps(1000);
    endtask

    initial begin
        logic [5:0] o, f;
        step_t s;
        rstn = 1'b0; run = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = '0; funct = '0;
        cur_op = '0; cur_funct = '0; cur_zero = 1'b0;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_ctl", 32'(obs), 32'(mk(0, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 0, NOP)));
        @(negedge clk);
        rstn = 1'b1;
        // idle holds while run=0, then leaves on run=1
        for (int i = 0; i < 3; i++) begin
            s.st = 4'd0; s.rdy = 1'($urandom_range(0, 1)); s.run = (i == 2);
            s.ctl = mk(0, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 0, NOP);
            q.push_back(s);
        end
        run_steps(3);

        do_instr(6'h00, 6'h20, 0, 0, 0);
        do_instr(6'h23, 6'h11, 0, 0, 3);
        do_instr(6'h04, 6'h00, 1, 0, 0);
        do_instr(6'h05, 6'h00, 1, 0, 0);
        do_instr(6'h03, 6'h00, 0, 0, 0);
        do_instr(6'h02, 6'h00, 0, 1, 0);
        do_instr(6'h2B, 6'h00, 0, 2, 1);
        do_instr(6'h08, 6'h00, 0, 0, 0);
        do_instr(6'h0D, 6'h00, 0, 0, 0);
        do_instr(6'h00, 6'h2B, 0, 0, 0);
        do_instr(6'h3F, 6'h00, 0, 0, 0);
        do_instr(6'h00, 6'h00, 0, 0, 0);
        do_instr(6'h00, 6'h22, 0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                do o = 6'($urandom); while (!legal_op(o));
            end else begin
                do o = 6'($urandom); while (legal_op(o));
            end
            if ($urandom_range(0, 9) < 8) f = 6'h20 + 6'($urandom_range(0, 11));
            else f = 6'($urandom);
            do_instr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // reset in the middle of an R-type execute
        add_instr(6'h00, 6'h20, 0, 0, 0);
        run_steps(3);
        q.delete();
        rstn = 1'b0;
        #1;
        chk("midreset_state", 32'(state), 32'd0);
        chk("midreset_ctl", 32'(obs), 32'(mk(0, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 0, NOP)));
        ill_m = 1'b0;
        @(negedge clk);
        rstn = 1'b1; run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("idle_hold", 32'(state), 32'd0);
            chk("idle_ctl", 32'(obs), 32'(mk(0, 0,0,0,0,0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 0, NOP)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
